// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared widths, operand/result types and bit helpers for the ceiling-log2 unit
//
// Purpose:
//   Default operand and result widths for log and log_msb_enc.
//   Named operand/result types.
//   A one-hot test used by the MSB encoder.
//
// Contents:
//   LOG_IN_W   default operand width (8)
//   LOG_OUT_W  default result width, $clog2(LOG_IN_W) (3)
//   LOG_MAX_W  widest operand is_onehot accepts; narrower operands are zero-extended
//   log_in_t   operand type
//   log_out_t  result type
//   is_onehot  true when exactly one bit of the argument is set

package log_pkg;

  localparam int LOG_IN_W  = 8;
  localparam int LOG_OUT_W = 3;
  localparam int LOG_MAX_W = 64;

  typedef logic [LOG_IN_W-1:0]  log_in_t;
  typedef logic [LOG_OUT_W-1:0] log_out_t;

  // Clearing the lowest set bit leaves zero only for a power of two.
  // Zero-extension does not change the answer, so one wide version covers
  // every operand width up to LOG_MAX_W.
  function automatic logic is_onehot(input logic [LOG_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - LOG_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/log_msb_enc.sv
// rtl/log_msb_enc.sv - combinational most-significant-set-bit encoder with zero and one-hot flags
//
// Purpose:
//   Finds the index of the highest set bit of the operand, which is floor(log2(in)).
//   Reports whether the operand is nonzero and whether it is an exact power of two.
//
// Parameters:
//   IN_W     operand width; must not exceed LOG_MAX_W
//   OUT_W    index width, $clog2(IN_W)
//
// Ports:
//   in       input   IN_W   unsigned operand
//   m        output  OUT_W  index of highest set bit; 0 when in == 0
//   nonzero  output  1      in != 0
//   onehot   output  1      exactly one bit of in is set

module log_msb_enc
  import log_pkg::*;
#(
  parameter int IN_W  = LOG_IN_W,
  parameter int OUT_W = LOG_OUT_W
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] m,
  output logic             nonzero,
  output logic             onehot
);

  logic [LOG_MAX_W-1:0] in_wide;

  // Scan from the MSB down. The first set bit seen wins, and later bits are ignored.
  always_comb begin
    m       = '0;
    nonzero = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!nonzero && in[i]) begin
        m       = OUT_W'(i);
        nonzero = 1'b1;
      end
    end
  end

  assign in_wide = LOG_MAX_W'(in);
  assign onehot  = is_onehot(in_wide);

endmodule

// File: rtl/log.sv
// rtl/log.sv - registered ceiling-log2 unit, one cycle latency, one result per cycle
//
// Purpose:
//   out = ceil(log2(in)) truncated to OUT_W bits, with a single valid-qualified
//   output register stage. There is no backpressure.
//   When in_valid is low, the result fields hold their last value.
//
// Optional build macro:
//   LOG_FLOOR_EN   adds out_floor = floor(log2(in)), registered alongside out
//
// Parameters:
//   IN_W   operand width (>= 2)
//   OUT_W  result width, must equal $clog2(IN_W)
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst_n      input   1      synchronous active-low reset
//   in_valid   input   1      qualifies in on this cycle
//   in         input   IN_W   unsigned operand
//   out_valid  output  1      out/ovf/is_pow2 are valid
//   out        output  OUT_W  ceil(log2(in)), low OUT_W bits
//   ovf        output  1      true result equals IN_W and does not fit in OUT_W
//   is_pow2    output  1      in is an exact nonzero power of two
//   out_floor  output  OUT_W  floor(log2(in)); 0 for in == 0 (LOG_FLOOR_EN only)

module log
  import log_pkg::*;
#(
  parameter int IN_W  = LOG_IN_W,
  parameter int OUT_W = LOG_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic             is_pow2
`ifdef LOG_FLOOR_EN
  ,
  output logic [OUT_W-1:0] out_floor
`endif
);

  logic [OUT_W-1:0] m;
  logic             nonzero;
  logic             onehot;
  logic [OUT_W:0]   r;

  log_msb_enc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_msb_enc (
    .in      (in),
    .m       (m),
    .nonzero (nonzero),
    .onehot  (onehot)
  );

  // A power of two (including 1) has ceil == floor. Any other nonzero value
  // rounds up by one. Zero falls through with m == 0.
  // The extra top bit of r catches the single case r == IN_W,
  // which appears as ovf with out wrapping to 0.
  always_comb begin
    r = {1'b0, m};
    if (nonzero && !onehot) begin
      r = {1'b0, m} + {{OUT_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      is_pow2   <= 1'b0;
`ifdef LOG_FLOOR_EN
      out_floor <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= r[OUT_W-1:0];
        ovf     <= r[OUT_W];
        is_pow2 <= onehot;
`ifdef LOG_FLOOR_EN
        out_floor <= m;
`endif
      end
    end
  end

endmodule

// File: tb/tb_log.sv
// tb/tb_log.sv - scoreboard testbench for the ceiling-log2 unit

module tb_log;
  import log_pkg::*;

  localparam int IW = LOG_IN_W;
  localparam int OW = LOG_OUT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_d = '0;
  logic          out_valid;
  logic [OW-1:0] out;
  logic          ovf;
  logic          is_pow2;
`ifdef LOG_FLOOR_EN
  logic [OW-1:0] out_floor;
`endif

  log #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_d),
    .out_valid (out_valid),
    .out       (out),
    .ovf       (ovf),
    .is_pow2   (is_pow2)
`ifdef LOG_FLOOR_EN
    ,
    .out_floor (out_floor)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    int ov;
    int p2;
    int fl;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the smallest k with 2^k >= v, and the largest k with 2^k <= v.
  function automatic exp_t model(input int v);
    exp_t e;
    int   c;
    int   f;
    c = 0;
    while ((1 << c) < v) c++;
    f = 0;
    while (v > 0 && (1 << (f + 1)) <= v) f++;
    e.o     = c % (1 << OW);
    e.ov    = c / (1 << OW);
    e.p2    = (v != 0 && $countones(v) == 1) ? 1 : 0;
    e.fl    = f;
    e.stamp = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d in_last=%0d", name, cyc, act, exp, in_d);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic drive(input bit rn, input bit v, input int val);
    exp_t e;
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    in_d     = IW'(val);
    if (rn && v) begin
      e       = model(val);
      e.stamp = cyc;
      q.push_back(e);
    end
  endtask

  // Monitor: uses the rst_n seen at each rising edge and checks the outputs on the following falling edge.
  initial begin : monitor
    exp_t hold;
    exp_t e;
    bit   r;
    hold = '{0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      if (!r) begin
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_is_pow2", int'(is_pow2), 0);
`ifdef LOG_FLOOR_EN
        check("rst_out_floor", int'(out_floor), 0);
`endif
        hold = '{0, 0, 0, 0, 0};
      end else if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid cyc=%0d got=1 expected=0", cyc);
        end else begin
          e = q.pop_front();
          check("latency", cyc - e.stamp, 1);
          check("out", int'(out), e.o);
          check("ovf", int'(ovf), e.ov);
          check("is_pow2", int'(is_pow2), e.p2);
`ifdef LOG_FLOOR_EN
          check("out_floor", int'(out_floor), e.fl);
`endif
          hold = e;
        end
      end else begin
        check("hold_out", int'(out), hold.o);
        check("hold_ovf", int'(ovf), hold.ov);
        check("hold_is_pow2", int'(is_pow2), hold.p2);
`ifdef LOG_FLOOR_EN
        check("hold_out_floor", int'(out_floor), hold.fl);
`endif
      end
      if (done) break;
    end
  end

  initial begin : stim
    int dir[] = '{5, 0, 1, 2, 3, 128, 129, 255};
    // Hold reset for 3 cycles while in_valid is high and in = 0xFF.
    for (int i = 0; i < 3; i++) drive(0, 1, 255);
    // Directed edge values, applied back-to-back.
    foreach (dir[i]) drive(1, 1, dir[i]);
    drive(1, 0, 0);
    // Streaming, then hold with in changing under in_valid = 0.
    drive(1, 1, 4);
    drive(1, 1, 9);
    drive(1, 1, 64);
    drive(1, 0, 200);
    drive(1, 0, 200);
    // Reset for one cycle mid-stream while in_valid is high.
    drive(1, 1, 77);
    drive(0, 1, 33);
    drive(1, 0, 0);
    drive(1, 1, 5);
    // Exhaustive sweep.
    for (int i = 0; i < (1 << IW); i++) drive(1, 1, i);
    // Random traffic with gaps and occasional resets.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 40) != 0, ($urandom % 4) != 0, int'($urandom_range(0, (1 << IW) - 1)));
    end
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    done = 1;
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
